// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: state encodings,
// bus widths, chip-enable levels and default reset/exception vectors.
package if_fetch_unit_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   localparam logic [InstAddrBus-1:0] ZeroWord     = '0;
   localparam logic                   ChipEnable   = 1'b1;
   localparam logic                   ChipDisable  = 1'b0;
   localparam logic [InstAddrBus-1:0] DefResetPc   = 32'h0000_0000;
   localparam logic [InstAddrBus-1:0] DefExcVector = 32'h0000_0020;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   function automatic logic [InstAddrBus-1:0] pc_plus4(input logic [InstAddrBus-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Pipeline-control, instruction-memory and IF/ID bundle of the fetch unit.
// slave = fetch unit side, master = surrounding pipeline / memory side.
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic                   stall_i;
   logic                   flush_i;
   logic [InstAddrBus-1:0] new_pc_i;
   logic                   branch_flag_i;
   logic [InstAddrBus-1:0] branch_target_i;
   logic                   rom_ce_o;
   logic [InstAddrBus-1:0] rom_addr_o;
   logic [InstBus-1:0]     rom_inst_i;
   logic [InstAddrBus-1:0] id_pc_o;
   logic [InstBus-1:0]     id_inst_o;
   logic                   id_valid_o;
   logic                   fetch_exc_o;

   modport slave (
      input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
      output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fetch_exc_o
   );

   modport master (
      output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i,
      input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o, fetch_exc_o
   );

endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// if_next_pc: pending-branch latch and priority next-PC mux
// (flush > stall > branch > PC+4). Alignment checking follows FETCH_ALIGN_CHK_EN.
module if_next_pc
   import if_fetch_unit_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] EXC_VECTOR = DefExcVector
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_run,
   input  logic                   i_stall,
   input  logic                   i_flush,
   input  logic [InstAddrBus-1:0] i_new_pc,
   input  logic                   i_branch,
   input  logic [InstAddrBus-1:0] i_branch_target,
   input  logic [InstAddrBus-1:0] i_pc,
   output logic [InstAddrBus-1:0] o_next_pc,
   output logic                   o_exc
);

   logic                   r_pend_vld;
   logic [InstAddrBus-1:0] r_pend_tgt;
   logic                   w_redirect;
   logic                   w_hold;
   logic [InstAddrBus-1:0] w_raw_tgt;
   logic [InstAddrBus-1:0] w_tgt;

   // A newer branch on a non-stalled edge wins over the pending one.
   always_comb begin
      w_redirect = 1'b0;
      w_hold     = 1'b0;
      w_raw_tgt  = ZeroWord;
      if (!i_run) begin
         w_hold = 1'b1;
      end else if (i_flush) begin
         w_redirect = 1'b1;
         w_raw_tgt  = i_new_pc;
      end else if (i_stall) begin
         w_hold = 1'b1;
      end else if (i_branch) begin
         w_redirect = 1'b1;
         w_raw_tgt  = i_branch_target;
      end else if (r_pend_vld) begin
         w_redirect = 1'b1;
         w_raw_tgt  = r_pend_tgt;
      end
   end

`ifdef FETCH_ALIGN_CHK_EN
   logic w_misalign;
   assign w_misalign = (w_raw_tgt[1:0] != 2'b00);
   assign w_tgt      = w_misalign ? EXC_VECTOR : w_raw_tgt;
   assign o_exc      = w_redirect & w_misalign;
`else
   assign w_tgt = w_raw_tgt & 32'hFFFF_FFFC;
   assign o_exc = 1'b0;
`endif

   assign o_next_pc = w_hold     ? i_pc :
                      w_redirect ? w_tgt : pc_plus4(i_pc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_tgt <= ZeroWord;
      end else if (!i_run || i_flush) begin
         r_pend_vld <= 1'b0;
      end else if (i_stall) begin
         if (i_branch) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= i_branch_target;
         end
      end else begin
         r_pend_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit top: IDLE/RUN/HOLD FSM, PC and IF/ID register.
// Optional misaligned-redirect trapping is enabled by defining FETCH_ALIGN_CHK_EN.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC   = DefResetPc,
   parameter logic [InstAddrBus-1:0] EXC_VECTOR = DefExcVector
) (
   input  logic          clk,
   input  logic          rst,
   if_fetch_unit_if.slave bus
);

   fetch_state_e           r_state;
   logic                   r_ce;
   logic [InstAddrBus-1:0] r_pc;
   logic [InstAddrBus-1:0] r_id_pc;
   logic [InstBus-1:0]     r_id_inst;
   logic                   r_id_valid;
   logic                   r_exc;
   logic                   w_run;
   logic [InstAddrBus-1:0] w_next_pc;
   logic                   w_exc;

   assign w_run = (r_state != ST_IDLE);

   if_next_pc #(.EXC_VECTOR(EXC_VECTOR)) u_next_pc (
      .clk             (clk),
      .rst             (rst),
      .i_run           (w_run),
      .i_stall         (bus.stall_i),
      .i_flush         (bus.flush_i),
      .i_new_pc        (bus.new_pc_i),
      .i_branch        (bus.branch_flag_i),
      .i_branch_target (bus.branch_target_i),
      .i_pc            (r_pc),
      .o_next_pc       (w_next_pc),
      .o_exc           (w_exc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ce       <= ChipDisable;
         r_pc       <= RESET_PC;
         r_id_pc    <= ZeroWord;
         r_id_inst  <= ZeroWord;
         r_id_valid <= 1'b0;
         r_exc      <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN, ST_HOLD: begin
               r_state <= bus.stall_i ? ST_HOLD : ST_RUN;
               r_ce    <= ChipEnable;
               r_pc    <= w_next_pc;
               r_exc   <= w_exc;
               // Flush kills the IF/ID slot even while stalled.
               if (bus.flush_i) begin
                  r_id_inst  <= ZeroWord;
                  r_id_valid <= 1'b0;
               end else if (!bus.stall_i) begin
                  r_id_pc    <= r_pc;
                  r_id_inst  <= bus.rom_inst_i;
                  r_id_valid <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_RUN;
               r_ce       <= ChipEnable;
               r_pc       <= RESET_PC;
               r_id_inst  <= ZeroWord;
               r_id_valid <= 1'b0;
               r_exc      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rom_ce_o    = r_ce;
   assign bus.rom_addr_o  = r_pc;
   assign bus.id_pc_o     = r_id_pc;
   assign bus.id_inst_o   = r_id_inst;
   assign bus.id_valid_o  = r_id_valid;
   assign bus.fetch_exc_o = r_exc;

endmodule
